// File: rtl/uart_mmio_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_mmio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 8;

  // A zero divisor would stall the baud counter, so it is promoted to 1.
  function automatic logic [15:0] sanitize_div(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational read data; push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PtrOne  = 1;
  localparam logic [AW:0]   CntOne  = 1;
  localparam logic [AW:0]   CntFull = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntFull);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: decodes a 16-byte window on the data bus, buffers
// written bytes in a FIFO and serialises them at a programmable baud divisor.
module mmio_uart_tx
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0]  BASE_ADDR   = 32'h0000_0100,
  parameter int unsigned  FIFO_DEPTH  = 8,
  parameter logic [15:0]  DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        hit,
  output logic        tx
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]      reg_off;
  logic            wr_txdata, wr_status, wr_bauddiv;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_dout;
  logic [CntW-1:0] fifo_count;

  logic            ovf_q;
  logic [15:0]     div_q;

  tx_state_t       state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [15:0]     frame_div_q, frame_div_d;
  logic            tx_q, tx_d;
  logic            start_frame;

  logic [31:0]     status;
  logic            unused_bits;

  assign unused_bits = ^{wd[31:16], a[1:0]};

  assign hit        = (a[31:4] == BASE_ADDR[31:4]);
  assign reg_off    = a[3:2];
  assign wr_txdata  = hit & we & (reg_off == REG_TXDATA);
  assign wr_status  = hit & we & (reg_off == REG_STATUS);
  assign wr_bauddiv = hit & we & (reg_off == REG_BAUDDIV);
  assign fifo_push  = wr_txdata & ~fifo_full;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wd[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      div_q <= DEFAULT_DIV;
    end else begin
      // A write that finds the FIFO full is dropped even if a pop frees a slot on this edge.
      if (wr_txdata && fifo_full) begin
        ovf_q <= 1'b1;
      end else if (wr_status && wd[STAT_OVF]) begin
        ovf_q <= 1'b0;
      end
      if (wr_bauddiv) div_q <= sanitize_div(wd[15:0]);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    frame_div_d = frame_div_q;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;
    tx_d        = 1'b1;

    unique case (state_q)
      IDLE: start_frame = ~fifo_empty;
      START: begin
        if (cnt_q == 16'd0) begin
          state_d = DATA;
          cnt_d   = frame_div_q - 16'd1;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = frame_div_q - 16'd1;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == 16'd0) begin
          if (!fifo_empty) start_frame = 1'b1;
          else             state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Divisor is captured per frame so mid-frame BAUDDIV writes only affect later frames.
    if (start_frame) begin
      fifo_pop    = 1'b1;
      shift_d     = fifo_dout;
      frame_div_d = div_q;
      cnt_d       = div_q - 16'd1;
      state_d     = START;
    end

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_div_q <= DEFAULT_DIV;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_div_q <= frame_div_d;
      tx_q        <= tx_d;
    end
  end

  assign tx = tx_q;

  always_comb begin
    status                          = '0;
    status[STAT_FULL]               = fifo_full;
    status[STAT_EMPTY]              = fifo_empty;
    status[STAT_BUSY]               = (state_q != IDLE);
    status[STAT_OVF]                = ovf_q;
    status[STAT_CNT_LSB +: CntW]    = fifo_count;
  end

  always_comb begin
    rd = '0;
    if (hit) begin
      unique case (reg_off)
        REG_STATUS:  rd = status;
        REG_BAUDDIV: rd = {16'h0000, div_q};
        default:     rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: frame-level model compared every cycle plus directed checks.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] A_TX = BASE;
  localparam logic [31:0] A_ST = BASE + 32'd4;
  localparam logic [31:0] A_BD = BASE + 32'd8;
  localparam logic [31:0] A_RS = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] a, wd, rd;
  logic        hit, tx;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd434)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd),
    .hit   (hit),
    .tx    (tx)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a byte queue plus the frame in flight, tracked as elapsed cycles since its start bit.
  logic [7:0]  m_q[$];
  logic        m_ovf    = 1'b0;
  logic        m_active = 1'b0;
  logic [15:0] m_div    = 16'd434;
  logic [15:0] m_fdiv   = 16'd1;
  logic [9:0]  m_frame  = 10'h3FF;
  int          m_el     = 0;
  logic        m_pre_full;

  task automatic m_start();
    m_frame  = {1'b1, m_q.pop_front(), 1'b0};
    m_fdiv   = m_div;
    m_el     = 0;
    m_active = 1'b1;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_ovf    = 1'b0;
      m_active = 1'b0;
      m_div    = 16'd434;
      m_el     = 0;
    end else begin
      m_pre_full = (m_q.size() == 8);
      if (m_active) begin
        m_el++;
        if (m_el == 10 * int'(m_fdiv)) begin
          if (m_q.size() > 0) m_start();
          else                m_active = 1'b0;
        end
      end else if (m_q.size() > 0) begin
        m_start();
      end
      if (we && a[31:4] == BASE[31:4]) begin
        case (a[3:2])
          2'd0: if (m_pre_full) m_ovf = 1'b1; else m_q.push_back(wd[7:0]);
          2'd1: if (wd[3]) m_ovf = 1'b0;
          2'd2: m_div = (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
          default: ;
        endcase
      end
    end
  end

  function automatic logic m_tx();
    if (!m_active) return 1'b1;
    return m_frame[m_el / int'(m_fdiv)];
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] addr);
    logic [31:0] s;
    s       = '0;
    s[0]    = (m_q.size() == 8);
    s[1]    = (m_q.size() == 0);
    s[2]    = m_active;
    s[3]    = m_ovf;
    s[11:8] = 4'(m_q.size());
    if (addr[31:4] != BASE[31:4]) return 32'h0;
    case (addr[3:2])
      2'd1:    return s;
      2'd2:    return {16'h0000, m_div};
      default: return 32'h0;
    endcase
  endfunction

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_tx", {31'b0, tx}, {31'b0, m_tx()});
      check("cyc_hit", {31'b0, hit}, {31'b0, (a[31:4] == BASE[31:4])});
      check("cyc_rd", rd, m_rd(a));
    end
  end

  task automatic bus(input logic w, input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk);
    #1;
    we = w;
    a  = addr;
    wd = data;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    bus(1'b0, addr, 32'h0);
    @(negedge clk);
    check(name, rd, exp);
  endtask

  logic trace  [0:255];
  logic btrace [0:255];

  task automatic measure(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      trace[i]  = tx;
      btrace[i] = rd[2];
    end
  endtask

  function automatic int fall_at(input int from, input int n);
    for (int i = from; i < n; i++) begin
      if (trace[i] == 1'b0 && (i == 0 || trace[i-1] == 1'b1)) return i;
    end
    return -1;
  endfunction

  function automatic int low_run(input int from, input int n);
    int k = 0;
    for (int i = from; i < n && i >= 0; i++) begin
      if (trace[i] != 1'b0) break;
      k++;
    end
    return k;
  endfunction

  function automatic int busy_cycles(input int n);
    int k = 0;
    for (int i = 0; i < n; i++) if (btrace[i] == 1'b1) k++;
    return k;
  endfunction

  task automatic wait_idle(input int max_cycles);
    int k = 0;
    while ((m_active || m_q.size() != 0) && k < max_cycles) begin
      @(negedge clk);
      k++;
    end
    if (k >= max_cycles) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", k);
    end
  endtask

  logic [9:0] pat;
  int         errs, f1, f2;

  initial begin
    reset = 1'b0;
    we    = 1'b0;
    a     = A_ST;
    wd    = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b1;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_status", rd, 32'h0000_0002);
    check("rst_tx", {31'b0, tx}, 32'd1);
    rd_chk("rst_bauddiv", A_BD, 32'd434);

    // Single 0xA5 frame at DIV=4
    bus(1'b1, A_BD, 32'd4);
    bus(1'b1, A_TX, 32'h0000_00A5);
    bus(1'b0, A_ST, 32'h0);
    @(negedge clk);
    check("a5_tx_before_start", {31'b0, tx}, 32'd1);
    pat  = 10'b11_0100_1010;
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx !== pat[i/4]) errs++;
    end
    check("a5_waveform_errors", errs, 0);
    rd_chk("a5_status_after", A_ST, 32'h0000_0002);

    // FIFO fill and overflow at DIV=2
    bus(1'b1, A_BD, 32'd2);
    for (int i = 0; i < 9; i++) bus(1'b1, A_TX, 32'h10 + i);
    rd_chk("fill_status", A_ST, 32'h0000_0805);
    bus(1'b1, A_TX, 32'h99);
    rd_chk("overflow_status", A_ST, 32'h0000_080D);
    bus(1'b1, A_ST, 32'h8);
    rd_chk("overflow_cleared", A_ST, 32'h0000_0805);
    wait_idle(1000);
    rd_chk("drain_status", A_ST, 32'h0000_0002);

    // Back-to-back 0x00, 0xFF at DIV=3
    bus(1'b1, A_BD, 32'd3);
    bus(1'b1, A_TX, 32'h00);
    bus(1'b1, A_TX, 32'hFF);
    bus(1'b0, A_ST, 32'h0);
    measure(80);
    f1 = fall_at(0, 80);
    f2 = fall_at(f1 + 1, 80);
    check("b2b_first_start", f1, 0);
    check("b2b_start_gap", f2 - f1, 30);
    check("b2b_busy_cycles", busy_cycles(80), 60);

    // Divisor change mid-frame: 5 cycles/bit, then 2 cycles/bit
    bus(1'b1, A_BD, 32'd5);
    fork
      measure(120);
      begin
        bus(1'b1, A_TX, 32'h00);
        bus(1'b1, A_TX, 32'h00);
        repeat (8) @(posedge clk);
        bus(1'b1, A_BD, 32'd2);
        bus(1'b0, A_ST, 32'h0);
      end
    join
    f1 = fall_at(0, 120);
    f2 = fall_at(f1 + 1, 120);
    check("div5_low_run", low_run(f1, 120), 45);
    check("div_change_gap", f2 - f1, 50);
    check("div2_low_run", low_run(f2, 120), 18);
    wait_idle(200);
    bus(1'b1, A_BD, 32'd0);
    rd_chk("bauddiv_zero_reads_one", A_BD, 32'd1);

    // Reset in the middle of DATA
    bus(1'b1, A_BD, 32'd4);
    bus(1'b1, A_TX, 32'h00);
    bus(1'b0, A_ST, 32'h0);
    repeat (12) @(posedge clk);
    #1;
    check("pre_reset_tx_low", {31'b0, tx}, 32'd0);
    #1;
    reset = 1'b0;
    #1;
    check("reset_tx_high", {31'b0, tx}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_status", rd, 32'h0000_0002);
    rd_chk("post_reset_bauddiv", A_BD, 32'd434);

    // Reserved offset, TXDATA readback and out-of-window addresses
    rd_chk("reserved_rd", A_RS, 32'h0);
    check("reserved_hit", {31'b0, hit}, 32'd1);
    bus(1'b1, A_RS, 32'hFFFF_FFFF);
    rd_chk("reserved_wr_status", A_ST, 32'h0000_0002);
    rd_chk("reserved_wr_bauddiv", A_BD, 32'd434);
    rd_chk("txdata_rd_zero", A_TX, 32'h0);
    rd_chk("outside_hi_rd", 32'h0000_0114, 32'h0);
    check("outside_hi_hit", {31'b0, hit}, 32'd0);
    rd_chk("outside_lo_rd", 32'h0000_00FC, 32'h0);
    check("outside_lo_hit", {31'b0, hit}, 32'd0);
    bus(1'b1, 32'h0000_0200, 32'h55);
    rd_chk("outside_wr_status", A_ST, 32'h0000_0002);
    repeat (3) @(negedge clk);
    check("outside_wr_tx_idle", {31'b0, tx}, 32'd1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the processor data bus, in parallel with `dmem`. It decodes its own address window on the same `we`/`a`/`wd` signals the processor drives into `dmem`, and buffers written bytes in a small FIFO. It serialises each byte as 8N1 on the DE2-115 serial pin. `top` selects `rd` from this block over `dmem` whenever `hit` is high.

## Interface
- `BASE_ADDR`, 32'h0000_0100: word-aligned base address of the register window. It sits just above the 64-word `dmem`.
- `FIFO_DEPTH`, 8: TX FIFO entries. Must be a power of two, at least 2.
- `DEFAULT_DIV`, 16'd434: baud divisor after reset (50 MHz / 115200).
- `clk`  in  1  system clock; every flop is clocked on its rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `we`  in  1  data-bus write enable (the processor's MemWrite).
- `a`  in  32  data-bus byte address.
- `wd`  in  32  data-bus write data.
- `rd`  out  32  read data. Combinational from `a` and the block's state.
- `hit`  out  1  combinational: `a[31:4] == BASE_ADDR[31:4]`.
- `tx`  out  1  serial output. Idles high. Registered.

## Operation
- Register map, offset given by `a[3:2]`:
  - 0 TXDATA (write-only; reads return 0).
  - 1 STATUS.
  - 2 BAUDDIV.
  - 3 reserved (reads return 0, writes are ignored).
- `rd` is 0 whenever `hit` is 0. Reads have no side effects.
- STATUS bit layout:
  - [0] full.
  - [1] empty.
  - [2] busy (FSM not in IDLE).
  - [3] overflow (sticky).
  - [11:8] FIFO count, zero-extended.
  - All other bits are 0.
- TXDATA write (`hit & we`): pushes `wd[7:0]`.
  - The push is accepted only if the FIFO was not full before the edge.
  - Otherwise the byte is dropped and overflow is set. This holds even when the FSM pops in the same cycle.
- STATUS write with `wd[3]=1` clears overflow. All other STATUS bits are read-only.
- BAUDDIV write: stores `wd[15:0]`, and a value of 0 is stored as 1.
  - The active divisor is latched when each frame starts, so a write mid-frame takes effect from the next frame.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE to START when the FIFO is non-empty. Same edge: pop the FIFO into the shift register and latch the divisor.
  - START to DATA after DIV cycles.
  - DATA sends 8 bits, LSB first, each for DIV cycles, then goes to STOP.
  - STOP drives `tx=1` for DIV cycles.
  - At the end of STOP: go to START with a pop if the FIFO is non-empty, otherwise go to IDLE.
- `tx` values: 1 in IDLE and STOP, 0 in START, shift-register LSB in DATA.
- Baud counter counts DIV-1 down to 0. At 0 it advances the bit and reloads.
- FIFO push and pop in the same cycle: both take effect and the count is unchanged.
- Reset values:
  - `tx`=1, state IDLE.
  - FIFO empty, count 0.
  - overflow 0, divisor `DEFAULT_DIV`.
  - `rd`/`hit` follow the inputs combinationally.
- Reset mid-frame: the frame is abandoned, `tx` returns to 1 immediately, and FIFO contents are lost.

## Timing
- Write accepted at edge E with FIFO empty and FSM idle:
  - count=1 after E.
  - At E+1 the FIFO pops and `tx` falls.
- Start bit occupies cycles [E+1, E+1+DIV).
- Data bit k occupies [E+1+(k+1)·DIV, E+1+(k+2)·DIV).
- Stop bit occupies [E+1+9·DIV, E+1+10·DIV).
- Back-to-back frames: the next start bit begins exactly at E+1+10·DIV, with no idle gap.
- busy rises at E+1 and falls at the end of the last stop bit when the FIFO is empty.

## Structure
- Package `uart_mmio_pkg` holds:
  - the `tx_state_t` enum (IDLE/START/DATA/STOP);
  - register offset constants (`REG_TXDATA`=0, `REG_STATUS`=1, `REG_BAUDDIV`=2);
  - STATUS bit-position constants.
- Sub-module `sync_fifo`, parameterised by width 8 and `FIFO_DEPTH`.
  - Ports: push, pop, din, dout, full, empty, count.
  - dout is combinational from the read pointer.
- Top-level glue instantiates the block beside `dmem` and muxes `ReadData = hit ? rd : dmem_rd`. `dmem` write enable is gated with `!hit`.

## Test plan
- Reset, then read STATUS: expect 0x0000_0002 and `tx`=1. Read BAUDDIV: expect 434.
- Write BAUDDIV=4, then write TXDATA=0xA5:
  - `tx` shows 0,1,0,1,0,0,1,0,1,1, each level held exactly 4 cycles, with the first 0 one cycle after the write edge.
  - STATUS then reads 0x0000_0002.
- With DIV=2, write 9 bytes back-to-back:
  - The 1st byte pops immediately and the next 8 fill the FIFO. STATUS reads full=1, count=8, overflow=0.
  - A 10th write is dropped: overflow=1 and count stays 8.
  - Writing STATUS with 0x8 clears overflow.
- Two bytes 0x00 and 0xFF at DIV=3: the second start bit begins exactly 30 cycles after the first. Busy stays high for 60 cycles.
- Write BAUDDIV=2 in the middle of a DIV=5 frame: the current frame finishes at 5 cycles per bit and the next frame runs at 2 cycles per bit. Writing BAUDDIV=0 reads back 1.
- Assert reset mid-DATA: `tx`=1 immediately and STATUS reads 0x2 after release. The reserved offset and addresses outside the window give `hit` as expected and `rd`=0.
